// File: rtl/wisc_pkg.sv
// Shared WISC-F18 datapath types and constants for the register file.
// Used by reg_file_16x16 and its reg_word cells.
package wisc_pkg;
    localparam int DATA_W    = 16;
    localparam int NUM_REGS  = 16;
    localparam int REG_IDX_W = 4;

    typedef logic [DATA_W-1:0]   word_t;
    typedef logic [NUM_REGS-1:0] wordline_t;

    // True when exactly one bit is set; all-zero is not one-hot.
    function automatic logic is_onehot(input wordline_t wl);
        return (wl != '0) && ((wl & (wl - wordline_t'(1))) == '0);
    endfunction
endpackage

// File: rtl/reg_word.sv
// One register-file word: async active-low reset, write enable, and two
// AND-gated read taps that drive zero onto a bitline when not selected.
module reg_word
    import wisc_pkg::*;
#(
    parameter int DATA_W = wisc_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    input  logic              rd_en1,
    input  logic              rd_en2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    logic [DATA_W-1:0] val_q, val_d;

    always_comb begin
        val_d = val_q;
        if (we) val_d = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) val_q <= '0;
        else        val_q <= val_d;
    end

    assign rd1 = rd_en1 ? val_q : '0;
    assign rd2 = rd_en2 ? val_q : '0;
endmodule

// File: rtl/reg_file_16x16.sv
// 16x16 register file: one-hot wired-OR read ports, decoded write port, and a
// registered read-select error flag. Define REGFILE_BYPASS_EN for write-through.
module reg_file_16x16
    import wisc_pkg::*;
#(
    parameter int DATA_W   = wisc_pkg::DATA_W,
    parameter int NUM_REGS = wisc_pkg::NUM_REGS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REGS-1:0]  RdWordline1,
    input  logic [NUM_REGS-1:0]  RdWordline2,
    input  logic [REG_IDX_W-1:0] DstReg,
    input  logic                 WriteReg,
    input  logic [DATA_W-1:0]    DstData,
    output logic [DATA_W-1:0]    SrcData1,
    output logic [DATA_W-1:0]    SrcData2,
    output logic                 RdSelErr
);
    logic [NUM_REGS-1:0]             wr_sel;
    logic [NUM_REGS-1:0][DATA_W-1:0] bl1, bl2;
    logic                            sel_err_q, sel_err_d;

    always_comb begin
        wr_sel = '0;
        if (WriteReg) wr_sel[DstReg] = 1'b1;
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
        reg_word #(.DATA_W(DATA_W)) u_word (
            .clk    (clk),
            .rst_n  (rst_n),
            .we     (wr_sel[i]),
            .d      (DstData),
            .rd_en1 (RdWordline1[i]),
            .rd_en2 (RdWordline2[i]),
            .rd1    (bl1[i]),
            .rd2    (bl2[i])
        );
    end

    // Bitline OR; with bypass, the word being written contributes DstData instead.
    always_comb begin
        SrcData1 = '0;
        SrcData2 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
`ifdef REGFILE_BYPASS_EN
            SrcData1 |= (wr_sel[i] && RdWordline1[i]) ? DstData : bl1[i];
            SrcData2 |= (wr_sel[i] && RdWordline2[i]) ? DstData : bl2[i];
`else
            SrcData1 |= bl1[i];
            SrcData2 |= bl2[i];
`endif
        end
    end

    always_comb begin
        sel_err_d = !is_onehot(RdWordline1) || !is_onehot(RdWordline2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_err_q <= 1'b0;
        else        sel_err_q <= sel_err_d;
    end

    assign RdSelErr = sel_err_q;
endmodule

// File: tb/tb_reg_file_16x16.sv
// Scoreboard bench for reg_file_16x16; expectations come from a local register model.
module tb_reg_file_16x16;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] RdWordline1, RdWordline2;
    logic [3:0]  DstReg;
    logic        WriteReg;
    logic [15:0] DstData;
    logic [15:0] SrcData1, SrcData2;
    logic        RdSelErr;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model [16];
    logic [15:0] exp_q [$];
    logic [15:0] exp_v;

    reg_file_16x16 dut (
        .clk(clk), .rst_n(rst_n), .RdWordline1(RdWordline1), .RdWordline2(RdWordline2),
        .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData),
        .SrcData1(SrcData1), .SrcData2(SrcData2), .RdSelErr(RdSelErr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [15:0] val);
        DstReg = idx; DstData = val; WriteReg = 1'b1;
        tick();
        WriteReg = 1'b0;
        model[idx] = val;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; WriteReg = 1'b0; DstReg = '0; DstData = '0;
        RdWordline1 = 16'h0001; RdWordline2 = 16'h0001;
        for (int i = 0; i < 16; i++) model[i] = '0;
        #12;
        checks++;
        if (SrcData1 !== 16'h0 || SrcData2 !== 16'h0 || RdSelErr !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got %h %h %b required 0000 0000 0", SrcData1, SrcData2, RdSelErr);
        end
        @(negedge clk); rst_n = 1'b1;
        wr(4'd3, 16'hBEEF);
        RdWordline1 = 16'h0008;
        exp_q.push_back(model[3]);
        #1; exp_v = exp_q.pop_front(); checks++;
        if (SrcData1 !== exp_v) begin
            errors++; $display("FAIL pre_reset_read: got %h required %h", SrcData1, exp_v);
        end
        // async assert mid-cycle: no clock edge before sampling
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        exp_q.push_back(16'h0000);
        #1; exp_v = exp_q.pop_front(); checks++;
        if (SrcData1 !== exp_v) begin
            errors++; $display("FAIL async_reset_read: got %h required %h", SrcData1, exp_v);
        end
        // pending write while reset held is dropped
        DstReg = 4'd4; DstData = 16'h7777; WriteReg = 1'b1;
        tick();
        WriteReg = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        RdWordline1 = 16'h0010;
        exp_q.push_back(model[4]);
        #1; exp_v = exp_q.pop_front(); checks++;
        if (SrcData1 !== exp_v) begin
            errors++; $display("FAIL write_during_reset: got %h required %h", SrcData1, exp_v);
        end
    endtask

    task automatic test_write_read_all();
        RdWordline1 = 16'h0001; RdWordline2 = 16'h0001;
        for (int i = 0; i < 16; i++) wr(4'(i), 16'(16'h1111 * i));
        for (int i = 0; i < 16; i++) begin
            RdWordline1 = 16'(1) << i;
            RdWordline2 = 16'(1) << (15 - i);
            exp_q.push_back(model[i]);
            exp_q.push_back(model[15 - i]);
            #1;
            exp_v = exp_q.pop_front(); checks++;
            if (SrcData1 !== exp_v) begin
                errors++; $display("FAIL read_all_p1 r%0d: got %h required %h", i, SrcData1, exp_v);
            end
            exp_v = exp_q.pop_front(); checks++;
            if (SrcData2 !== exp_v) begin
                errors++; $display("FAIL read_all_p2 r%0d: got %h required %h", 15 - i, SrcData2, exp_v);
            end
        end
        RdWordline1 = 16'h0001; RdWordline2 = 16'h8000;
        #1; checks++;
        if (SrcData1 !== 16'h0000 || SrcData2 !== 16'hFFFF) begin
            errors++; $display("FAIL r0_r15: got %h %h required 0000 ffff", SrcData1, SrcData2);
        end
        RdWordline1 = 16'h0100; RdWordline2 = 16'h0100;
        exp_q.push_back(model[8]);
        #1; exp_v = exp_q.pop_front(); checks++;
        if (SrcData1 !== exp_v || SrcData2 !== exp_v) begin
            errors++; $display("FAIL same_reg_both: got %h %h required %h", SrcData1, SrcData2, exp_v);
        end
    endtask

    task automatic test_hold();
        DstReg = 4'd5; DstData = 16'hAAAA; WriteReg = 1'b0;
        repeat (4) tick();
        RdWordline1 = 16'h0020;
        exp_q.push_back(model[5]);
        #1; exp_v = exp_q.pop_front(); checks++;
        if (SrcData1 !== exp_v || exp_v !== 16'h5555) begin
            errors++; $display("FAIL write_hold: got %h required %h", SrcData1, exp_v);
        end
    endtask

    task automatic test_same_cycle();
        wr(4'd7, 16'h1234);
        RdWordline2 = 16'h0080;
        DstReg = 4'd7; DstData = 16'h4321; WriteReg = 1'b1;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(16'h4321);
`else
        exp_q.push_back(model[7]);
`endif
        #1; exp_v = exp_q.pop_front(); checks++;
        if (SrcData2 !== exp_v) begin
            errors++; $display("FAIL rdw_before_edge: got %h required %h", SrcData2, exp_v);
        end
        tick();
        WriteReg = 1'b0;
        model[7] = 16'h4321;
        exp_q.push_back(model[7]);
        #1; exp_v = exp_q.pop_front(); checks++;
        if (SrcData2 !== exp_v) begin
            errors++; $display("FAIL rdw_after_edge: got %h required %h", SrcData2, exp_v);
        end
    endtask

    task automatic test_multi_hot();
        RdWordline1 = 16'h0001; RdWordline2 = 16'h0002;
        wr(4'd1, 16'h00F0);
        wr(4'd2, 16'h0F00);
        checks++;
        if (RdSelErr !== 1'b0) begin
            errors++; $display("FAIL err_idle: got %b required 0", RdSelErr);
        end
        RdWordline1 = 16'h0006;
        exp_q.push_back(model[1] | model[2]);
        #1; exp_v = exp_q.pop_front(); checks++;
        if (SrcData1 !== exp_v) begin
            errors++; $display("FAIL multi_hot_or: got %h required %h", SrcData1, exp_v);
        end
        // multi-hot read while writing one of the selected words
        DstReg = 4'd1; DstData = 16'h00AA; WriteReg = 1'b1;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(16'h00AA | model[2]);
`else
        exp_q.push_back(model[1] | model[2]);
`endif
        #1; exp_v = exp_q.pop_front(); checks++;
        if (SrcData1 !== exp_v) begin
            errors++; $display("FAIL multi_hot_write: got %h required %h", SrcData1, exp_v);
        end
        tick();
        WriteReg = 1'b0;
        model[1] = 16'h00AA;
        checks++;
        if (RdSelErr !== 1'b1) begin
            errors++; $display("FAIL err_set_multi: got %b required 1", RdSelErr);
        end
        RdWordline1 = 16'h0000;
        exp_q.push_back(16'h0000);
        #1; exp_v = exp_q.pop_front(); checks++;
        if (SrcData1 !== exp_v) begin
            errors++; $display("FAIL zero_wordline: got %h required %h", SrcData1, exp_v);
        end
        tick();
        checks++;
        if (RdSelErr !== 1'b1) begin
            errors++; $display("FAIL err_stays_zero: got %b required 1", RdSelErr);
        end
        RdWordline1 = 16'h0002;
        #1; checks++;
        if (RdSelErr !== 1'b1) begin
            errors++; $display("FAIL err_latency: got %b required 1", RdSelErr);
        end
        tick();
        checks++;
        if (RdSelErr !== 1'b0) begin
            errors++; $display("FAIL err_clear: got %b required 0", RdSelErr);
        end
        // error from port 2 alone, with a write in flight that must still land
        RdWordline2 = 16'h0000;
        wr(4'd9, 16'hC0DE);
        checks++;
        if (RdSelErr !== 1'b1) begin
            errors++; $display("FAIL err_port2: got %b required 1", RdSelErr);
        end
        RdWordline2 = 16'h0200;
        exp_q.push_back(model[9]);
        #1; exp_v = exp_q.pop_front(); checks++;
        if (SrcData2 !== exp_v) begin
            errors++; $display("FAIL write_with_err: got %h required %h", SrcData2, exp_v);
        end
        tick();
        checks++;
        if (RdSelErr !== 1'b0) begin
            errors++; $display("FAIL err_clear_p2: got %b required 0", RdSelErr);
        end
    endtask

    initial begin
        test_reset();
        test_write_read_all();
        test_hold();
        test_same_cycle();
        test_multi_hot();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
